// File: rtl/bit_receiver_if.sv
// Word-side bundle of the JTAG TDI deserializer: serial sample inputs, the
// completed-word valid/ready handshake and the status outputs.
interface bit_receiver_if #(
    parameter int WIDTH = 32
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic             enable;
    logic             in;
    logic             flush;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             word_ready;
    logic [CW-1:0]    bit_count;
    logic             overrun;
    logic             clear_overrun;

    // master: the deserializer itself; slave: the bit source and word consumer
    modport master (
        input  enable, in, flush, word_ready, clear_overrun,
        output word_out, word_valid, bit_count, overrun
    );

    modport slave (
        output enable, in, flush, word_ready, clear_overrun,
        input  word_out, word_valid, bit_count, overrun
    );
endinterface

// File: rtl/bit_receiver.sv
// MSB-first serial-to-parallel deserializer with a single-entry valid/ready
// holding register and a sticky overrun flag for words dropped while full.
module bit_receiver #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    bit_receiver_if.master bus
);
    localparam int            CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] next_word;
    logic [WIDTH-1:0] word_q;
    logic             valid_q;
    logic [CW-1:0]    count_q;
    logic             overrun_q;

    logic sample;
    logic complete;
    logic take;
    logic load;
    logic drop;

    // NOTE: every always_comb output is assigned unconditionally on every pass,
    // so no path can leave a value held over and infer a latch.
    always_comb begin
        sample    = bus.enable && !bus.flush;
        complete  = sample && (count_q == LAST_BIT);
        next_word = {shreg[WIDTH-2:0], bus.in};
        take      = valid_q && bus.word_ready;
        load      = complete && (!valid_q || bus.word_ready);
        drop      = complete && valid_q && !bus.word_ready;
    end

    // NOTE: the shift register carries no reset; a word is only ever delivered
    // after WIDTH fresh samples have pushed every old bit out.
    always_ff @(posedge clk) begin
        if (sample) begin
            shreg <= next_word;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_q    <= '0;
            valid_q   <= 1'b0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            // flush wins over enable, so the bit presented with it is lost
            if (bus.flush) begin
                count_q <= '0;
            end else if (bus.enable) begin
                count_q <= complete ? '0 : count_q + CW'(1);
            end

            // a completion can refill the slot on the very edge it drains
            if (load) begin
                word_q  <= next_word;
                valid_q <= 1'b1;
            end else if (take) begin
                valid_q <= 1'b0;
            end

            if (drop) begin
                overrun_q <= 1'b1;
            end else if (bus.clear_overrun) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign bus.word_out   = word_q;
    assign bus.word_valid = valid_q;
    assign bus.bit_count  = count_q;
    assign bus.overrun    = overrun_q;

    count_in_range: assert property (@(posedge clk) count_q <= LAST_BIT);

endmodule

// File: tb/tb_bit_receiver.sv
// Directed bench for bit_receiver: MSB-first words with hand-computed
// expectations covering gating, overrun, back-to-back, flush and reset.
module tb_bit_receiver;
    localparam int WIDTH = 32;
    localparam int CW    = $clog2(WIDTH) + 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int vec_count   = 0;
    int miscompares = 0;

    bit_receiver_if #(.WIDTH(WIDTH)) bus ();

    bit_receiver #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends w[hi] down to w[lo]; between bits, gap disabled cycles drive the inverted bit
    task automatic send_bits(input logic [31:0] w, input int hi, input int lo, input int gap);
        for (int i = hi; i >= lo; i--) begin
            bus.enable = 1'b1;
            bus.in     = w[i];
            step();
            if (i != lo) begin
                for (int g = 0; g < gap; g++) begin
                    bus.enable = 1'b0;
                    bus.in     = ~w[i];
                    step();
                end
            end
        end
        bus.enable = 1'b0;
        bus.in     = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        vec_count++;
        if (bus.word_out !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_word_out: got %h expected %h", bus.word_out, 32'h0);
        end
        vec_count++;
        if (bus.word_valid !== 1'b0 || bus.overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got valid=%b overrun=%b expected 0 0", bus.word_valid, bus.overrun);
        end
        vec_count++;
        if (bus.bit_count !== CW'(0)) begin
            miscompares++;
            $display("FAIL reset_bit_count: got %0d expected 0", bus.bit_count);
        end
    endtask

    task automatic test_basic_word();
        bus.word_ready = 1'b1;
        send_bits(32'hDEADBEEF, 31, 16, 0);
        vec_count++;
        if (bus.bit_count !== CW'(16) || bus.word_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_midword: got count=%0d valid=%b expected 16 0", bus.bit_count, bus.word_valid);
        end
        send_bits(32'hDEADBEEF, 15, 0, 0);
        vec_count++;
        if (bus.word_valid !== 1'b1 || bus.word_out !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL basic_word: got valid=%b out=%h expected 1 deadbeef", bus.word_valid, bus.word_out);
        end
        vec_count++;
        if (bus.bit_count !== CW'(0)) begin
            miscompares++;
            $display("FAIL basic_wrap: got count=%0d expected 0", bus.bit_count);
        end
        step();
        vec_count++;
        if (bus.word_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_consume: got valid=%b expected 0", bus.word_valid);
        end
    endtask

    task automatic test_enable_gating();
        bus.word_ready = 1'b0;
        send_bits(32'hA5A5A5A5, 31, 27, 1);
        vec_count++;
        if (bus.bit_count !== CW'(5)) begin
            miscompares++;
            $display("FAIL gate_count_enabled: got %0d expected 5", bus.bit_count);
        end
        bus.in = ~bus.in;
        step();
        vec_count++;
        if (bus.bit_count !== CW'(5)) begin
            miscompares++;
            $display("FAIL gate_count_hold: got %0d expected 5", bus.bit_count);
        end
        send_bits(32'hA5A5A5A5, 26, 0, 1);
        vec_count++;
        if (bus.word_valid !== 1'b1 || bus.word_out !== 32'hA5A5A5A5) begin
            miscompares++;
            $display("FAIL gate_word: got valid=%b out=%h expected 1 a5a5a5a5", bus.word_valid, bus.word_out);
        end
        bus.word_ready = 1'b1;
        step();
        bus.word_ready = 1'b0;
        vec_count++;
        if (bus.word_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL gate_consume: got valid=%b expected 0", bus.word_valid);
        end
    endtask

    task automatic test_overrun();
        bus.word_ready = 1'b0;
        send_bits(32'h12345678, 31, 0, 0);
        vec_count++;
        if (bus.word_valid !== 1'b1 || bus.word_out !== 32'h12345678 || bus.overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL ovr_first: got valid=%b out=%h ovr=%b expected 1 12345678 0",
                     bus.word_valid, bus.word_out, bus.overrun);
        end
        send_bits(32'hCAFEF00D, 31, 0, 0);
        vec_count++;
        if (bus.word_valid !== 1'b1 || bus.word_out !== 32'h12345678) begin
            miscompares++;
            $display("FAIL ovr_hold: got valid=%b out=%h expected 1 12345678", bus.word_valid, bus.word_out);
        end
        vec_count++;
        if (bus.overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL ovr_set: got %b expected 1", bus.overrun);
        end
        bus.word_ready = 1'b1;
        step();
        bus.word_ready = 1'b0;
        vec_count++;
        if (bus.word_valid !== 1'b0 || bus.word_out !== 32'h12345678 || bus.overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL ovr_consume: got valid=%b out=%h ovr=%b expected 0 12345678 1",
                     bus.word_valid, bus.word_out, bus.overrun);
        end
        bus.clear_overrun = 1'b1;
        step();
        bus.clear_overrun = 1'b0;
        vec_count++;
        if (bus.overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL ovr_clear: got %b expected 0", bus.overrun);
        end
    endtask

    task automatic test_back_to_back();
        bus.word_ready = 1'b0;
        send_bits(32'h11223344, 31, 0, 0);
        send_bits(32'h55667788, 31, 1, 0);
        vec_count++;
        if (bus.word_valid !== 1'b1 || bus.word_out !== 32'h11223344) begin
            miscompares++;
            $display("FAIL b2b_first: got valid=%b out=%h expected 1 11223344", bus.word_valid, bus.word_out);
        end
        bus.word_ready = 1'b1;
        send_bits(32'h55667788, 0, 0, 0);
        vec_count++;
        if (bus.word_valid !== 1'b1 || bus.word_out !== 32'h55667788 || bus.overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_second: got valid=%b out=%h ovr=%b expected 1 55667788 0",
                     bus.word_valid, bus.word_out, bus.overrun);
        end
        step();
        vec_count++;
        if (bus.word_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_drain: got valid=%b expected 0", bus.word_valid);
        end
    endtask

    task automatic test_flush();
        bus.word_ready = 1'b1;
        send_bits(32'hFFFFFFFF, 31, 22, 0);
        vec_count++;
        if (bus.bit_count !== CW'(10)) begin
            miscompares++;
            $display("FAIL flush_pre: got count=%0d expected 10", bus.bit_count);
        end
        bus.enable = 1'b1;
        bus.flush  = 1'b1;
        bus.in     = 1'b1;
        step();
        bus.enable = 1'b0;
        bus.flush  = 1'b0;
        vec_count++;
        if (bus.bit_count !== CW'(0) || bus.word_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_count: got count=%0d valid=%b expected 0 0", bus.bit_count, bus.word_valid);
        end
        send_bits(32'h0F0F0F0F, 31, 0, 0);
        vec_count++;
        if (bus.word_valid !== 1'b1 || bus.word_out !== 32'h0F0F0F0F) begin
            miscompares++;
            $display("FAIL flush_word: got valid=%b out=%h expected 1 0f0f0f0f", bus.word_valid, bus.word_out);
        end
        step();
    endtask

    task automatic test_reset_midword();
        bus.word_ready = 1'b0;
        send_bits(32'hAAAA5555, 31, 0, 0);
        send_bits(32'h00000000, 31, 0, 0);
        send_bits(32'h13579BDF, 31, 15, 0);
        vec_count++;
        if (bus.word_valid !== 1'b1 || bus.bit_count !== CW'(17) || bus.overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_pre: got valid=%b count=%0d ovr=%b expected 1 17 1",
                     bus.word_valid, bus.bit_count, bus.overrun);
        end
        reset      = 1'b1;
        bus.enable = 1'b1;
        bus.in     = 1'b1;
        step();
        reset      = 1'b0;
        bus.enable = 1'b0;
        bus.in     = 1'b0;
        vec_count++;
        if (bus.word_out !== 32'h0 || bus.word_valid !== 1'b0 ||
            bus.bit_count !== CW'(0) || bus.overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid: got out=%h valid=%b count=%0d ovr=%b expected 0 0 0 0",
                     bus.word_out, bus.word_valid, bus.bit_count, bus.overrun);
        end
        send_bits(32'h600DCAFE, 31, 0, 0);
        send_bits(32'hBADC0DE5, 31, 1, 0);
        bus.clear_overrun = 1'b1;
        send_bits(32'hBADC0DE5, 0, 0, 0);
        vec_count++;
        if (bus.overrun !== 1'b1 || bus.word_out !== 32'h600DCAFE) begin
            miscompares++;
            $display("FAIL set_beats_clear: got ovr=%b out=%h expected 1 600dcafe", bus.overrun, bus.word_out);
        end
        step();
        bus.clear_overrun = 1'b0;
        vec_count++;
        if (bus.overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_after: got %b expected 0", bus.overrun);
        end
    endtask

    initial begin
        bus.enable        = 1'b0;
        bus.in            = 1'b0;
        bus.flush         = 1'b0;
        bus.word_ready    = 1'b0;
        bus.clear_overrun = 1'b0;

        test_reset();
        test_basic_word();
        test_enable_gating();
        test_overrun();
        test_back_to_back();
        test_flush();
        test_reset_midword();

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end
endmodule

// File: doc/bit_receiver.md
Name: bit_receiver

Overview:
Serial-to-parallel deserializer for the JTAG data path. It samples one bit per enabled clock, MSB-first, which matches the bit ordering of the 32-bit serial transmitter. It presents each completed WIDTH-bit word through a single-entry valid/ready holding register. It sits on the TDI side of the data register chain and feeds the word-consuming logic. A sticky error flag records dropped words.

Parameters:
WIDTH, 32, word length in bits (≥2).
CW, $clog2(WIDTH)+1, width of bit_count; must not be overridden.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  sample strobe; in is captured on a rising edge where enable=1
in  input  1  serial data bit
flush  input  1  discard the partially assembled word
word_out  output  WIDTH  completed word; first received bit at [WIDTH-1]
word_valid  output  1  word_out holds an unconsumed word
word_ready  input  1  consumer accepts word_out when word_valid=1
bit_count  output  CW  bits held in the partial word, range 0..WIDTH-1
overrun  output  1  sticky; a completed word was dropped
clear_overrun  input  1  clears overrun

Behaviour:
- Reset (synchronous, highest priority) forces the following values; the shift register contents are don't-care:
  - word_out=0
  - word_valid=0
  - bit_count=0
  - overrun=0
- Reset mid-word discards the partial word and any held word, with no overrun.
- Shift register: on an edge with enable=1 and flush=0, shreg <= {shreg[WIDTH-2:0], in} and bit_count increments.
  - enable=0 holds all state except handshake consumption.
  - in is ignored when enable=0.
- Completion: the edge where enable=1, flush=0 and bit_count==WIDTH-1 delivers the word {shreg[WIDTH-2:0], in}.
  - bit_count wraps to 0 on that edge.
  - If word_valid=0, or word_valid=1 and word_ready=1 on that edge: the word loads into word_out and word_valid=1 from the next cycle. Latency is 1 cycle after the last bit's edge.
  - If word_valid=1 and word_ready=0: the new word is dropped, word_out/word_valid are unchanged, and overrun<=1.
- Handshake:
  - A transfer happens on an edge with word_valid=1 and word_ready=1.
  - If no completion occurs on the same edge, word_valid<=0 and word_out holds its stale value.
  - word_out is stable while word_valid=1 and word_ready=0.
  - word_ready while word_valid=0 has no effect.
- flush:
  - bit_count<=0 and the partial word is discarded.
  - flush beats enable on the same edge, so that bit is lost.
  - flush does not affect word_out, word_valid or overrun.
- overrun: set beats clear_overrun on the same edge. Otherwise clear_overrun=1 forces 0. The flag stays set until cleared or reset.
- Continuous streaming: the consumer has WIDTH enabled cycles after word_valid rises to accept the word before the next completion overruns.
- No X on any output after the first reset edge.

Test Plan:
1. Reset, then 32 enabled bits of 0xDEADBEEF MSB-first with word_ready=1 -> one cycle after bit 32, word_valid=1 and word_out=0xDEADBEEF; bit_count=0; consumed the next edge, so word_valid=0.
2. enable toggling 1/0 every cycle while sending 0xA5A5A5A5 -> bit_count advances only on enabled edges; the word completes after 32 enabled edges; value correct.
3. Send 0x12345678 with word_ready=0, then 0xCAFEF00D with word_ready still 0 -> word_out stays 0x12345678 and overrun=1. Raise word_ready -> 0x12345678 is consumed and word_valid=0. Pulse clear_overrun -> overrun=0.
4. Back-to-back words with word_ready asserted only on the completion edge of the second word -> word_out switches directly to the second word, word_valid stays 1, no overrun.
5. After 10 bits, assert flush together with enable -> bit_count=0. The next 32 bits form 0x0F0F0F0F exactly, with no residue of the first 10 bits.
6. Assert reset with word_valid=1, bit_count=17 and overrun=1 -> next cycle all outputs are 0. clear_overrun and an overrun event on the same edge -> overrun=1.
